// File: rtl/pe_pkg.sv
// Shared definitions for the PE command sequencer: opcodes, the per-function
// result latency table, FSM state encoding and completion status codes.
package pe_pkg;

  // Deepest result latency of any PE function; sizes the valid-tracking pipe.
  localparam int MAX_LAT = 6;

  // PE function opcodes.
  localparam logic [3:0] FN1 = 4'd1;
  localparam logic [3:0] FN2 = 4'd2;
  localparam logic [3:0] FN3 = 4'd3;
  localparam logic [3:0] FN4 = 4'd4;
  localparam logic [3:0] FN5 = 4'd5;
  localparam logic [3:0] FN6 = 4'd6;
  localparam logic [3:0] FN7 = 4'd7;
  localparam logic [3:0] FN8 = 4'd8;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ABORT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Completion status, valid while Done is high.
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_BAD_OP   = 2'b01;
  localparam logic [1:0] ERR_UNDERRUN = 2'b10;

  // Cycles from an operand first appearing at the PE inputs to its result
  // appearing on the PE output.
  function automatic logic [2:0] lat_of(input logic [3:0] op);
    logic [2:0] lat;
    case (op)
      FN1:     lat = 3'd2;
      FN2:     lat = 3'd4;
      FN3:     lat = 3'd2;
      FN4:     lat = 3'd2;
      FN5:     lat = 3'd2;
      FN6:     lat = 3'd2;
      FN7:     lat = 3'd4;
      FN8:     lat = 3'd6;
      default: lat = 3'd1;
    endcase
    return lat;
  endfunction

  // True for opcodes the PE implements.
  function automatic logic op_is_valid(input logic [3:0] op);
    return (op >= FN1) && (op <= FN8);
  endfunction

endpackage

// File: rtl/pe_valid_pipe.sv
// Valid-tracking shift register: one bit per in-flight PE operand, advancing
// every cycle, with a selectable output tap and a synchronous clear.
module pe_valid_pipe #(
  parameter int DEPTH = 6,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_in,
  input  logic [SEL_W-1:0] tap_sel,
  output logic             tap_out
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Shift a new bit in each cycle unless the pipe is being flushed.
  always_comb begin
    pipe_d = {pipe_q[DEPTH-2:0], shift_in};
    if (clr) begin
      pipe_d = '0;
    end
  end

  // Pipe register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Tap mux; a select beyond the pipe depth reads as 0.
  always_comb begin
    tap_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == SEL_W'(i)) begin
        tap_out = pipe_q[i];
      end
    end
  end

endmodule

// File: rtl/pe_cmd_sequencer.sv
// Command-driven controller for the M216A processing element. Accepts a
// function/count command, flushes the PE, streams exactly count operand
// triples with no gaps, and tags the PE results with a valid strobe derived
// from the per-function latency table.
//
// Handshakes: Cmd and S are valid/ready streams. A transfer happens on a
// rising clock edge where both valid and ready are high; ready depends only
// on the current state, never on valid. M has no ready: M_Valid is a strobe.
module pe_cmd_sequencer #(
  parameter int DW            = 16,
  parameter int CNT_W         = 8,
  parameter int PE_RST_CYCLES = 2,
  parameter int MAX_LAT       = pe_pkg::MAX_LAT
) (
  input  logic             Clk_In,
  input  logic             Rst_In,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [3:0]       Cmd_Op,
  input  logic [CNT_W-1:0] Cmd_Cnt,
  input  logic             S_Valid,
  output logic             S_Ready,
  input  logic [DW-1:0]    S_D1,
  input  logic [DW-1:0]    S_D2,
  input  logic [DW-1:0]    S_D3,
  output logic             Pe_Rst_Out,
  output logic [15:0]      Pe_Instr_Out,
  output logic [DW-1:0]    Pe_D1_Out,
  output logic [DW-1:0]    Pe_D2_Out,
  output logic [DW-1:0]    Pe_D3_Out,
  input  logic [DW-1:0]    Pe_D_Out,
  output logic             M_Valid,
  output logic [DW-1:0]    M_Data,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Err,
  output logic [2:0]       Dbg_State_Out
);

  import pe_pkg::*;

  localparam int TMR_W = 8;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       err_q, err_d;
  logic [DW-1:0]    d1_q, d1_d;
  logic [DW-1:0]    d2_q, d2_d;
  logic [DW-1:0]    d3_q, d3_d;
  logic             dvld_q, dvld_d;

  logic [2:0]       lat_cur;
  logic [2:0]       tap_sel;
  logic             in_stream;
  logic             pipe_clr;
  logic             tap_out;

  assign lat_cur   = lat_of(op_q);
  assign tap_sel   = lat_cur - 3'd1;
  assign in_stream = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // Anything left in the pipe outside RUN/DRAIN belongs to a dead command.
  assign pipe_clr  = !in_stream;

  // Next-state and datapath-register logic for the command FSM.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    d1_d    = '0;
    d2_d    = '0;
    d3_d    = '0;
    dvld_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Cmd_Valid) begin
          op_d  = Cmd_Op;
          cnt_d = Cmd_Cnt;
          err_d = ERR_OK;
          if (!op_is_valid(Cmd_Op)) begin
            err_d   = ERR_BAD_OP;
            state_d = ST_DONE;
          end else if (Cmd_Cnt == '0) begin
            state_d = ST_DONE;
          end else begin
            tmr_d   = TMR_W'(PE_RST_CYCLES - 1);
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (tmr_q == '0) begin
          state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_RUN: begin
        if (S_Valid) begin
          d1_d   = S_D1;
          d2_d   = S_D2;
          d3_d   = S_D3;
          dvld_d = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // DRAIN spans LAT+1 cycles: the last operand is on the PE inputs
            // in the first DRAIN cycle and its result lands LAT cycles later.
            tmr_d   = TMR_W'(lat_cur);
            state_d = ST_DRAIN;
          end
        end else begin
          // Stateful PE functions cannot tolerate a bubble in the stream.
          err_d   = ERR_UNDERRUN;
          state_d = ST_ABORT;
        end
      end
      ST_DRAIN: begin
        if (tmr_q == '0) begin
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_ABORT: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      err_q   <= ERR_OK;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      dvld_q  <= dvld_d;
    end
  end

  // The pipe is fed from the registered operand-valid flag so that tap k is
  // high exactly k+1 cycles after the operand first sits on the PE inputs.
  pe_valid_pipe #(
    .DEPTH (MAX_LAT),
    .SEL_W (3)
  ) u_valid_pipe (
    .clk      (Clk_In),
    .rst      (Rst_In),
    .clr      (pipe_clr),
    .shift_in (dvld_q),
    .tap_sel  (tap_sel),
    .tap_out  (tap_out)
  );

  // State-decoded outputs toward the command, operand and PE interfaces.
  always_comb begin
    Cmd_Ready     = (state_q == ST_IDLE);
    Busy          = (state_q != ST_IDLE);
    S_Ready       = (state_q == ST_RUN);
    Pe_Rst_Out    = !in_stream;
    Pe_Instr_Out  = '0;
    if ((state_q == ST_FLUSH) || in_stream) begin
      Pe_Instr_Out = 16'(op_q);
    end
    Pe_D1_Out     = d1_q;
    Pe_D2_Out     = d2_q;
    Pe_D3_Out     = d3_q;
    M_Valid       = in_stream & tap_out;
    M_Data        = Pe_D_Out;
    Done          = (state_q == ST_DONE);
    Err           = err_q;
    Dbg_State_Out = state_q;
  end

endmodule

// File: tb/tb_pe_cmd_sequencer.sv
// Self-checking bench for pe_cmd_sequencer. A small behavioural PE model
// produces Pe_D_Out with the per-function latency; expected results are
// queued when triples are accepted and compared on each M_Valid strobe.
module tb_pe_cmd_sequencer;

  localparam int DW = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             Rst_In;
  logic             Cmd_Valid;
  logic             Cmd_Ready;
  logic [3:0]       Cmd_Op;
  logic [CNT_W-1:0] Cmd_Cnt;
  logic             S_Valid;
  logic             S_Ready;
  logic [DW-1:0]    S_D1, S_D2, S_D3;
  logic             Pe_Rst_Out;
  logic [15:0]      Pe_Instr_Out;
  logic [DW-1:0]    Pe_D1_Out, Pe_D2_Out, Pe_D3_Out;
  logic [DW-1:0]    Pe_D_Out;
  logic             M_Valid;
  logic [DW-1:0]    M_Data;
  logic             Busy;
  logic             Done;
  logic [1:0]       Err;
  logic [2:0]       Dbg_State_Out;

  pe_cmd_sequencer #(
    .DW            (DW),
    .CNT_W         (CNT_W),
    .PE_RST_CYCLES (2),
    .MAX_LAT       (6)
  ) dut (
    .Clk_In        (clk),
    .Rst_In        (Rst_In),
    .Cmd_Valid     (Cmd_Valid),
    .Cmd_Ready     (Cmd_Ready),
    .Cmd_Op        (Cmd_Op),
    .Cmd_Cnt       (Cmd_Cnt),
    .S_Valid       (S_Valid),
    .S_Ready       (S_Ready),
    .S_D1          (S_D1),
    .S_D2          (S_D2),
    .S_D3          (S_D3),
    .Pe_Rst_Out    (Pe_Rst_Out),
    .Pe_Instr_Out  (Pe_Instr_Out),
    .Pe_D1_Out     (Pe_D1_Out),
    .Pe_D2_Out     (Pe_D2_Out),
    .Pe_D3_Out     (Pe_D3_Out),
    .Pe_D_Out      (Pe_D_Out),
    .M_Valid       (M_Valid),
    .M_Data        (M_Data),
    .Busy          (Busy),
    .Done          (Done),
    .Err           (Err),
    .Dbg_State_Out (Dbg_State_Out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int pulse_cnt = 0;
  int first_pulse_cyc = -1;
  int done_cnt = 0;
  bit s_ready_seen = 0;
  bit rst_low_seen = 0;
  bit rdy_busy = 0;
  logic [3:0] cur_op = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bench's own latency table and PE function model.
  function automatic int tb_lat(input logic [3:0] op);
    case (op)
      4'd2, 4'd7: return 4;
      4'd8:       return 6;
      4'd1, 4'd3, 4'd4, 4'd5, 4'd6: return 2;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [DW-1:0] pe_f(input logic [3:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b, input logic [DW-1:0] c);
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return b + c;
      4'd4: return a ^ b;
      4'd5: return a & c;
      4'd6: return a + c;
      4'd7: return b - c;
      4'd8: return a + 16'd1;
      default: return '0;
    endcase
  endfunction

  // PE model: the result of the operands present in cycle c appears in cycle c+LAT.
  logic [DW-1:0] hist [8] = '{default: '0};
  initial Pe_D_Out = '0;
  always @(negedge clk) begin
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = pe_f(Pe_Instr_Out[3:0], Pe_D1_Out, Pe_D2_Out, Pe_D3_Out);
    Pe_D_Out = hist[tb_lat(cur_op)];
  end

  // Output monitor: pops the expected queue on every result strobe.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    #1;
    if (Busy && Cmd_Ready) rdy_busy = 1;
    if (S_Ready) s_ready_seen = 1;
    if (!Pe_Rst_Out) rst_low_seen = 1;
    if (Done) done_cnt++;
    if (M_Valid) begin
      pulse_cnt++;
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("m_valid_unexpected", 32'(M_Valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", 32'(M_Data), 32'(e));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [3:0] op, input int cnt, input int gap_at, input int rst_at,
                         input logic [1:0] exp_err, input int exp_pulses, input bit rnd);
    int n, i, acc_cyc, first_acc, done_cyc, pcnt;
    bit gapped;
    logic [DW-1:0] a, b, c;
    @(negedge clk);
    n = 0;
    while (!Cmd_Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!Cmd_Ready) begin
      chk("cmd_ready_timeout", 32'(Cmd_Ready), 32'd1);
      return;
    end
    cur_op = op;
    pulse_cnt = 0;
    first_pulse_cyc = -1;
    done_cnt = 0;
    s_ready_seen = 0;
    rst_low_seen = 0;
    rdy_busy = 0;
    exp_q.delete();
    Cmd_Valid = 1'b1;
    Cmd_Op = op;
    Cmd_Cnt = CNT_W'(cnt);
    acc_cyc = cyc;
    @(negedge clk);
    Cmd_Valid = 1'b0;
    i = 0;
    n = 0;
    gapped = 0;
    first_acc = -1;
    a = '0; b = '0; c = '0;
    while (i < cnt && !Done && n < 300 && !gapped) begin
      if (rst_at >= 0 && i == rst_at) begin
        Rst_In = 1'b1;
        S_Valid = 1'b0;
        @(negedge clk);
        Rst_In = 1'b0;
        exp_q.delete();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
        chk("rst_m_valid", 32'(M_Valid), 32'd0);
        chk("rst_pe_rst", 32'(Pe_Rst_Out), 32'd1);
        chk("rst_pre_pulses", 32'(pulse_cnt), 32'(exp_pulses));
        pcnt = pulse_cnt;
        repeat (10) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_no_pulses", 32'(pulse_cnt), 32'(pcnt));
        return;
      end
      if (gap_at == i && S_Ready) begin
        S_Valid = 1'b0;
        gapped = 1;
        @(negedge clk);
        chk("abort_pe_rst", 32'(Pe_Rst_Out), 32'd1);
        chk("abort_m_valid", 32'(M_Valid), 32'd0);
      end else begin
        if (rnd) begin
          a = DW'($urandom_range(0, 16'hFFFF));
          b = DW'($urandom_range(0, 16'hFFFF));
          c = DW'($urandom_range(0, 16'hFFFF));
        end else begin
          a = DW'(i + 1);
          b = DW'(i + 4);
          c = DW'(i + 8);
        end
        S_Valid = 1'b1;
        S_D1 = a;
        S_D2 = b;
        S_D3 = c;
        if (S_Ready) begin
          exp_q.push_back(pe_f(op, a, b, c));
          if (i == 0) first_acc = cyc;
          i++;
        end
        @(negedge clk);
        n++;
      end
    end
    S_Valid = 1'b0;
    n = 0;
    while (!Done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!Done) begin
      chk("done_timeout", 32'(Done), 32'd1);
      return;
    end
    done_cyc = cyc;
    chk("err", 32'(Err), 32'(exp_err));
    chk("busy_at_done", 32'(Busy), 32'd1);
    chk("pe_rst_at_done", 32'(Pe_Rst_Out), 32'd1);
    if (exp_err == 2'b01 || cnt == 0) begin
      chk("quick_done", 32'(done_cyc - acc_cyc <= 2), 32'd1);
      chk("no_s_ready", 32'(s_ready_seen), 32'd0);
      chk("no_pe_activity", 32'(rst_low_seen), 32'd0);
    end
    @(negedge clk);
    chk("busy_drop", 32'(Busy), 32'd0);
    chk("cmd_ready_back", 32'(Cmd_Ready), 32'd1);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
    chk("cmd_ready_while_busy", 32'(rdy_busy), 32'd0);
    if (exp_err == 2'b00) begin
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      if (cnt > 0) chk("first_latency", 32'(first_pulse_cyc - first_acc - 1), 32'(tb_lat(op)));
    end
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] op;
    int         cnt;
    int         gap_at;
    logic [1:0] err;
    int         pulses;
    bit         rnd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{op: 4'd3,  cnt: 4,  gap_at: -1, err: 2'b00, pulses: 4,  rnd: 0};
    vecs[1]  = '{op: 4'd8,  cnt: 6,  gap_at: -1, err: 2'b00, pulses: 6,  rnd: 0};
    vecs[2]  = '{op: 4'd6,  cnt: 5,  gap_at: 2,  err: 2'b10, pulses: 0,  rnd: 0};
    vecs[3]  = '{op: 4'd9,  cnt: 3,  gap_at: -1, err: 2'b01, pulses: 0,  rnd: 0};
    vecs[4]  = '{op: 4'd0,  cnt: 3,  gap_at: -1, err: 2'b01, pulses: 0,  rnd: 0};
    vecs[5]  = '{op: 4'd1,  cnt: 3,  gap_at: -1, err: 2'b00, pulses: 3,  rnd: 0};
    vecs[6]  = '{op: 4'd2,  cnt: 2,  gap_at: -1, err: 2'b00, pulses: 2,  rnd: 0};
    vecs[7]  = '{op: 4'd5,  cnt: 0,  gap_at: -1, err: 2'b00, pulses: 0,  rnd: 0};
    vecs[8]  = '{op: 4'd7,  cnt: 8,  gap_at: 5,  err: 2'b10, pulses: 1,  rnd: 0};
    vecs[9]  = '{op: 4'd4,  cnt: 2,  gap_at: -1, err: 2'b00, pulses: 2,  rnd: 1};
    vecs[10] = '{op: 4'd8,  cnt: 1,  gap_at: -1, err: 2'b00, pulses: 1,  rnd: 1};
    vecs[11] = '{op: 4'd15, cnt: 5,  gap_at: -1, err: 2'b01, pulses: 0,  rnd: 0};
    vecs[12] = '{op: 4'd2,  cnt: 12, gap_at: -1, err: 2'b00, pulses: 12, rnd: 1};

    Rst_In = 1'b1;
    Cmd_Valid = 1'b0;
    Cmd_Op = '0;
    Cmd_Cnt = '0;
    S_Valid = 1'b0;
    S_D1 = '0;
    S_D2 = '0;
    S_D3 = '0;
    repeat (3) @(negedge clk);

    chk("reset_cmd_ready", 32'(Cmd_Ready), 32'd1);
    chk("reset_s_ready", 32'(S_Ready), 32'd0);
    chk("reset_pe_rst", 32'(Pe_Rst_Out), 32'd1);
    chk("reset_instr", 32'(Pe_Instr_Out), 32'd0);
    chk("reset_d1", 32'(Pe_D1_Out), 32'd0);
    chk("reset_d2", 32'(Pe_D2_Out), 32'd0);
    chk("reset_d3", 32'(Pe_D3_Out), 32'd0);
    chk("reset_m_valid", 32'(M_Valid), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_err", 32'(Err), 32'd0);
    Rst_In = 1'b0;

    for (int k = 0; k < 13; k++) begin
      run_cmd(vecs[k].op, vecs[k].cnt, vecs[k].gap_at, -1, vecs[k].err, vecs[k].pulses, vecs[k].rnd);
    end

    // Reset mid-RUN of op 7: two results land before reset, then nothing.
    run_cmd(4'd7, 8, -1, 6, 2'b00, 2, 0);
    // A clean command right after the mid-command reset.
    run_cmd(4'd4, 2, -1, -1, 2'b00, 2, 0);
    // Back-to-back pair again with random operands.
    run_cmd(4'd1, 3, -1, -1, 2'b00, 3, 1);
    run_cmd(4'd2, 2, -1, -1, 2'b00, 2, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_cmd_sequencer.md
Name: pe_cmd_sequencer

Overview:
Command-driven controller that sequences the M216A processing element (PE).
- Accepts a command (function opcode plus sample count) and flushes the PE with a reset pulse.
- Streams exactly N operand triples into the PE with no gaps.
- Tags each PE result with a valid strobe using the per-function latency table.
- Sits between the system command/operand streams and the PE top module, which has no enable or valid of its own.

Parameters:
- DW, 16, operand/result width.
- CNT_W, 8, width of sample count.
- PE_RST_CYCLES, 2, cycles Pe_Rst_Out is held high in FLUSH (min 1).
- MAX_LAT, 6, depth of the valid-tracking shift register.

Ports:
- Clk_In  in  1  clock, single clock domain.
- Rst_In  in  1  synchronous, active-high reset.
- Cmd_Valid  in  1  command offered.
- Cmd_Ready  out  1  command accepted when Cmd_Valid & Cmd_Ready.
- Cmd_Op  in  4  PE function 1..8.
- Cmd_Cnt  in  CNT_W  number of operand triples.
- S_Valid  in  1  operand triple available.
- S_Ready  out  1  operand consumed when S_Valid & S_Ready.
- S_D1, S_D2, S_D3  in  DW each  operands.
- Pe_Rst_Out  out  1  to PE Rst_In.
- Pe_Instr_Out  out  16  to PE Instruction_In; zero-extended opcode.
- Pe_D1_Out, Pe_D2_Out, Pe_D3_Out  out  DW each  to PE D_In1..3.
- Pe_D_Out  in  DW  from PE D_Out.
- M_Valid  out  1  result strobe. No backpressure.
- M_Data  out  DW  equals Pe_D_Out.
- Busy  out  1  high outside IDLE.
- Done  out  1  one-cycle pulse at command end.
- Err  out  2  status, valid with Done: 00 ok, 01 bad opcode, 10 operand underrun.

Behaviour:
- Reset values: Cmd_Ready=1, S_Ready=0, Pe_Rst_Out=1, Pe_Instr_Out=0, Pe_D*_Out=0, M_Valid=0, Busy=0, Done=0, Err=0.
- Rst_In at any time, including mid-command, returns to IDLE the next cycle and clears the valid pipe. No Done is generated.
- Latency table LAT(op): 1→2, 2→4, 3→2, 4→2, 5→2, 6→2, 7→4, 8→6.
- Latency convention: a result appears on Pe_D_Out LAT cycles after its operand is first driven on Pe_D*_Out.
- IDLE:
  - Cmd_Ready=1, Pe_Rst_Out=1.
  - On accept, latch op and cnt.
  - op outside 1..8 → DONE with Err=01, no PE activity.
  - cnt=0 → DONE with Err=00.
  - Otherwise → FLUSH.
- FLUSH:
  - Pe_Rst_Out=1 and Pe_Instr_Out=op for PE_RST_CYCLES cycles; operands driven 0.
  - Then → RUN.
- RUN:
  - Pe_Rst_Out=0, S_Ready=1.
  - Each accepted triple is registered onto Pe_D*_Out and the remaining count decrements.
  - A 1 is shifted into the valid pipe for each accepted triple.
  - If S_Valid=0 in any RUN cycle → ABORT. Stateful functions 6/7/8 cannot tolerate gaps.
  - After the last triple → DRAIN.
- DRAIN:
  - S_Ready=0; operand registers hold 0 and a 0 is shifted into the pipe each cycle.
  - Wait LAT(op) cycles so the last result emerges, then → DONE, Err=00.
- ABORT:
  - Pe_Rst_Out=1 for one cycle, valid pipe cleared.
  - → DONE with Err=10.
- DONE:
  - Done=1 for one cycle, Err held stable that cycle.
  - Pe_Rst_Out=1, → IDLE.
- Busy=1 in FLUSH, RUN, DRAIN, ABORT and DONE. Cmd_Ready=0 whenever Busy.
- Valid pipe: MAX_LAT-bit shift register advancing every cycle. M_Valid = tap[LAT(op)-1], forced 0 outside RUN/DRAIN.
- M_Valid asserts exactly cnt times per successful command.
- Arithmetic: only the CNT_W-bit down-counter and the latency counter; no datapath arithmetic. Result width and wrap are the PE's responsibility.

Decomposition:
- Shared package pe_pkg holds:
  - opcode constants FN1..FN8;
  - LAT table function/constants and MAX_LAT;
  - state enum {IDLE, FLUSH, RUN, DRAIN, ABORT, DONE};
  - Err codes.
- One natural sub-module: pe_valid_pipe, the MAX_LAT shift register with a selectable tap and synchronous clear.

Test Plan:
- Op=3, cnt=4, triples (1,4,8),(2,5,9),(3,6,10),(4,7,11) streamed continuously → 4 M_Valid pulses with M_Data 12,14,16,18. First pulse 2 cycles after the first operand is driven. Done then Err=00.
- Op=8, cnt=6, D1=1..6 → first M_Valid exactly 6 cycles after the first operand. Exactly 6 pulses. Busy drops the cycle after Done.
- Op=6, cnt=5, S_Valid dropped for 1 cycle after the 2nd triple → ABORT: Pe_Rst_Out pulses, M_Valid stops, Done with Err=10.
- Op=9, cnt=3, and separately op=0 → Done within 2 cycles, Err=01, S_Ready never 1, Pe_Rst_Out stays 1.
- Two back-to-back commands (op=1 cnt=3, then op=2 cnt=2) → Cmd_Ready=0 until IDLE. Second command gets its own FLUSH and LAT=4 tagging. Totals 3 and 2 pulses.
- Rst_In asserted mid-RUN of op=7 cnt=8 → next cycle IDLE, M_Valid=0, no Done. A following op=4 cnt=2 runs cleanly.
